change_dispenser: RTL and testbench
===================================

# change_dispenser

Sequential coin-return engine for the vending machine; it pays out the balance left after a purchase. On a return request it latches the remaining balance and emits one coin per accepted cycle, largest denomination first, under a ready handshake with the coin hopper. It sits after the purchase path: it consumes the same balance register the item dispenser deducts from, and drives the physical coin outputs.

## Interface
Parameters:
- BAL_W, 32: balance width in bits.
- COIN0_VAL, 100: smallest coin value.
- COIN1_VAL, 500: middle coin value.
- COIN2_VAL, 1000: largest coin value; values are strictly increasing.

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- i_start  input  1  return request; sampled only in IDLE.
- i_balance  input  BAL_W  balance to return; latched with i_start.
- i_coin_ready  input  1  hopper can accept a coin this cycle.
- o_return_coin  output  3  one-hot registered coin pulse: [0]=COIN0, [1]=COIN1, [2]=COIN2.
- o_busy  output  1  high whenever state is not IDLE.
- o_done  output  1  one-cycle completion pulse.
- o_residual  output  BAL_W  unreturnable amount (< COIN0_VAL) from the last completed return.
- o_coin_count  output  24  per-denomination counts, {cnt2, cnt1, cnt0}, 8 bits each (see Configuration).

## Operation
- States: IDLE, DISPENSE, DONE.
- Internal register rem, BAL_W bits.
- IDLE:
  - If i_start=1, latch rem <= i_balance and go to DISPENSE.
  - If i_start=0, stay in IDLE.
- DISPENSE, evaluated at each rising edge:
  - If rem < COIN0_VAL: o_residual <= rem and go to DONE. No coin is issued.
  - Else if i_coin_ready=1: select the largest coin with value <= rem, set rem <= rem - value, and set the matching o_return_coin bit for exactly one cycle.
  - Else (i_coin_ready=0): o_return_coin <= 0, rem is held, and the block stays in DISPENSE.
- DONE: o_done=1 (Moore output); the next edge returns to IDLE.
- Arithmetic: unsigned, and no underflow is possible because a coin is only chosen when its value <= rem.
- i_start while o_busy=1 is ignored, and i_balance changes after latching have no effect.
- o_return_coin is never multi-hot and is zero outside DISPENSE.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, rem=0, o_return_coin=0, o_busy=0, o_done=0, o_residual=0, o_coin_count=0.
- Reset mid-DISPENSE aborts the return. Coins already pulsed remain counted as paid; the rest is lost.
- Start edge E0 moves the block to DISPENSE; o_busy rises after E0.
- The first coin decision happens at E1, and that coin's pulse is visible between E1 and E2.
- With N coins and i_coin_ready held high, DONE is entered at edge E(N+1) and o_done is high between E(N+1) and E(N+2). IDLE resumes at E(N+2).
- Each cycle with i_coin_ready=0 adds exactly one cycle of latency.
- i_start may be reasserted in the first IDLE cycle after DONE and is accepted at that edge.
- o_residual holds its value until the next DONE or reset.

## Configuration
- Macro: CHANGE_COIN_COUNT_EN.
- Defined:
  - Three 8-bit saturating counters, one per denomination, each incremented on its coin pulse.
  - A counter at 255 stays at 255.
  - Counters clear only on reset.
  - o_coin_count reflects the counters.
- Undefined: no counter registers are built and o_coin_count is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- i_balance=1600, i_start 1 cycle, i_coin_ready=1 -> coin pulses 1000, 500, 100 on consecutive cycles; o_done 4 edges after start; o_residual=0.
- i_balance=0 -> no coin pulse; o_done 1 edge after start; o_residual=0.
- i_balance=250 -> 100, 100; o_residual=50; o_done 3 edges after start.
- i_balance=1500 with i_coin_ready low for 2 cycles after start -> first coin (1000) delayed 2 cycles; rem held; sequence 1000, 500; i_start pulse mid-dispense with i_balance=900 ignored.
- reset_n=0 after the first coin of 2100 -> all outputs 0 next cycle, state IDLE; a new start with 500 returns one 500 coin.
- CHANGE_COIN_COUNT_EN defined, 300 returns of 100 -> cnt0 saturates at 255, cnt1=cnt2=0; undefined -> o_coin_count=0 throughout.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin-return engine: latches a balance and pays it out one coin per accepted cycle, largest first.
// Optional per-denomination saturating coin counters are built when CHANGE_COIN_COUNT_EN is defined.
module change_dispenser #(
    parameter int BAL_W     = 32,
    parameter int COIN0_VAL = 100,
    parameter int COIN1_VAL = 500,
    parameter int COIN2_VAL = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [BAL_W-1:0] i_balance,
    input  logic             i_coin_ready,
    output logic [2:0]       o_return_coin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BAL_W-1:0] o_residual,
    output logic [23:0]      o_coin_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [BAL_W-1:0] C0_V = BAL_W'(COIN0_VAL);
    localparam logic [BAL_W-1:0] C1_V = BAL_W'(COIN1_VAL);
    localparam logic [BAL_W-1:0] C2_V = BAL_W'(COIN2_VAL);

    state_t           state_r;
    logic [BAL_W-1:0] rem_r;
    logic [2:0]       coin_r;
    logic             busy_r;
    logic             done_r;
    logic [BAL_W-1:0] residual_r;
    logic [2:0]       coin_sel_s;
    logic [BAL_W-1:0] coin_val_s;

    // Pick the largest coin not exceeding the remaining balance
    always_comb begin
        coin_sel_s = 3'b000;
        coin_val_s = {BAL_W{1'b0}};
        if (rem_r >= C2_V) begin
            coin_sel_s = 3'b100;
            coin_val_s = C2_V;
        end else if (rem_r >= C1_V) begin
            coin_sel_s = 3'b010;
            coin_val_s = C1_V;
        end else if (rem_r >= C0_V) begin
            coin_sel_s = 3'b001;
            coin_val_s = C0_V;
        end else begin
            coin_sel_s = 3'b000;
            coin_val_s = {BAL_W{1'b0}};
        end
    end

    // Return FSM with registered coin, busy, done and residual outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            rem_r      <= {BAL_W{1'b0}};
            coin_r     <= 3'b000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            residual_r <= {BAL_W{1'b0}};
        end else begin
            coin_r <= 3'b000;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        rem_r   <= i_balance;
                        state_r <= DISPENSE;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                DISPENSE: begin
                    if (rem_r < C0_V) begin
                        residual_r <= rem_r;
                        state_r    <= DONE;
                        done_r     <= 1'b1;
                    end else if (i_coin_ready) begin
                        rem_r  <= rem_r - coin_val_s;
                        coin_r <= coin_sel_s;
                    end else begin
                        rem_r  <= rem_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_return_coin = coin_r;
    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_residual    = residual_r;

`ifdef CHANGE_COIN_COUNT_EN
    logic [2:0][7:0] cnt_r;
    logic            issue_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // A coin is issued on the same edge that raises its pulse
    always_comb begin
        issue_s = 1'b0;
        if (state_r == DISPENSE && rem_r >= C0_V && i_coin_ready) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Saturating per-denomination counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= {3{8'd0}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (issue_s && coin_sel_s[i]) begin
                    cnt_r[i] <= sat_inc8(cnt_r[i]);
                end
            end
        end
    end

    assign o_coin_count = cnt_r;
`else
    assign o_coin_count = 24'd0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed cases plus randomized returns against a greedy model.
module tb_change_dispenser;

    localparam int C0 = 100;
    localparam int C1 = 500;
    localparam int C2 = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_balance;
    logic        i_coin_ready;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_residual;
    logic [23:0] o_coin_count;

    int errors = 0;
    int checks = 0;
    int mcnt[3];
    int edges;

    change_dispenser #(.BAL_W(32), .COIN0_VAL(C0), .COIN1_VAL(C1), .COIN2_VAL(C2)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_balance(i_balance),
        .i_coin_ready(i_coin_ready), .o_return_coin(o_return_coin), .o_busy(o_busy),
        .o_done(o_done), .o_residual(o_residual), .o_coin_count(o_coin_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef CHANGE_COIN_COUNT_EN
        int s[3];
        for (int i = 0; i < 3; i++) s[i] = (mcnt[i] > 255) ? 255 : mcnt[i];
        return 32'(s[2] * 65536 + s[1] * 256 + s[0]);
`else
        return 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high; 1: random ready and stray starts; 2: two stall cycles then ready
    task automatic run_return(input logic [31:0] bal, input int mode, output int edges_to_done);
        int q[$];
        int r, n, cyc, idx;
        logic rdy, seen;
        r = bal;
        n = r / C2; r -= n * C2; repeat (n) q.push_back(2);
        n = r / C1; r -= n * C1; repeat (n) q.push_back(1);
        n = r / C0; r -= n * C0; repeat (n) q.push_back(0);
        i_start = 1'b1;
        i_balance = bal;
        step();
        i_start = 1'b0;
        i_balance = $urandom;
        check("busy_after_start", 32'(o_busy), 32'd1);
        check("coin_after_start", 32'(o_return_coin), 32'd0);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            case (mode)
                0: rdy = 1'b1;
                2: rdy = (cyc >= 2);
                default: rdy = 1'(($urandom % 2));
            endcase
            i_coin_ready = rdy;
            if (mode == 2 && cyc == 1) begin
                i_start = 1'b1;
                i_balance = 32'd900;
            end else if (mode == 1) begin
                i_start = 1'($urandom % 2);
            end else begin
                i_start = 1'b0;
            end
            step();
            cyc++;
            if (q.size() == 0) begin
                check("done_pulse", 32'(o_done), 32'd1);
                check("coin_in_done", 32'(o_return_coin), 32'd0);
                check("residual", o_residual, 32'(r));
                check("busy_in_done", 32'(o_busy), 32'd1);
                seen = 1'b1;
            end else if (rdy) begin
                idx = q.pop_front();
                mcnt[idx]++;
                check("coin_pulse", 32'(o_return_coin), 32'd1 << idx);
                check("done_low", 32'(o_done), 32'd0);
                check("coin_count", 32'(o_coin_count), exp_count());
            end else begin
                check("coin_stall", 32'(o_return_coin), 32'd0);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        edges_to_done = cyc;
        i_start = 1'b0;
        step();
        check("busy_idle", 32'(o_busy), 32'd0);
        check("done_idle", 32'(o_done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        reset_n = 1'b0;
        i_start = 1'b0;
        i_balance = 32'd0;
        i_coin_ready = 1'b1;
        step();
        step();
        check("rst_coin", 32'(o_return_coin), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_residual", o_residual, 32'd0);
        check("rst_count", 32'(o_coin_count), 32'd0);
        reset_n = 1'b1;
        step();

        run_return(32'd1600, 0, edges);
        check("lat_1600", 32'(edges), 32'd4);
        run_return(32'd0, 0, edges);
        check("lat_0", 32'(edges), 32'd1);
        run_return(32'd250, 0, edges);
        check("lat_250", 32'(edges), 32'd3);
        run_return(32'd1500, 2, edges);
        check("lat_1500_stall", 32'(edges), 32'd5);

        // Abort a 2100 return after its first coin
        i_start = 1'b1;
        i_balance = 32'd2100;
        i_coin_ready = 1'b1;
        step();
        i_start = 1'b0;
        step();
        check("abort_first_coin", 32'(o_return_coin), 32'd4);
        mcnt[2]++;
        check("abort_count", 32'(o_coin_count), exp_count());
        reset_n = 1'b0;
        step();
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        check("abort_coin", 32'(o_return_coin), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_residual", o_residual, 32'd0);
        check("abort_cnt_clear", 32'(o_coin_count), 32'd0);
        reset_n = 1'b1;
        step();
        run_return(32'd500, 0, edges);
        check("lat_500", 32'(edges), 32'd2);

        for (int k = 0; k < 30; k++) begin
            run_return(32'($urandom_range(0, 5000)), 1, edges);
        end

        // Drive the smallest-coin counter into saturation
        reset_n = 1'b0;
        step();
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 300; k++) begin
            run_return(32'($urandom_range(100, 199)), 0, edges);
        end
        check("sat_final", 32'(o_coin_count), exp_count());
`ifdef CHANGE_COIN_COUNT_EN
        check("sat_cnt0", 32'(o_coin_count[7:0]), 32'd255);
`else
        check("count_tied_zero", 32'(o_coin_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
